// File: rtl/dplca_aging_multi_if.sv
// dplca_aging_multi_if: control and status bundle of the DPLCA
// TXOP-claim aging engine (master = claim source, slave = engine).
interface dplca_aging_multi_if #(
    parameter int NUM_IDS = 256,
    parameter int ID_W    = 8,
    parameter int CNT_W   = 16
);
    logic                   dplca_aging;
    logic                   dplca_txop_end;
    logic [1:0]             dplca_txop_claim;
    logic [ID_W-1:0]        dplca_txop_id;
    logic [CNT_W-1:0]       hard_aging_cycles;
    logic [CNT_W-1:0]       soft_aging_cycles;
    logic [2*NUM_IDS-1:0]   claim_table;
    logic [2:0]             state;
    logic [CNT_W-1:0]       long_cnt;
    logic [CNT_W-1:0]       short_cnt;
    logic                   dplca_new_age;
    logic                   dplca_txop_table_upd;

    modport master (
        output dplca_aging,
        output dplca_txop_end,
        output dplca_txop_claim,
        output dplca_txop_id,
        output hard_aging_cycles,
        output soft_aging_cycles,
        input  claim_table,
        input  state,
        input  long_cnt,
        input  short_cnt,
        input  dplca_new_age,
        input  dplca_txop_table_upd
    );

    modport slave (
        input  dplca_aging,
        input  dplca_txop_end,
        input  dplca_txop_claim,
        input  dplca_txop_id,
        input  hard_aging_cycles,
        input  soft_aging_cycles,
        output claim_table,
        output state,
        output long_cnt,
        output short_cnt,
        output dplca_new_age,
        output dplca_txop_table_upd
    );
endinterface

// File: rtl/dplca_aging_multi.sv
// dplca_aging_multi: DPLCA TXOP-claim aging engine with a live and a
// shadow claim table, aged on independent HARD and SOFT cycle counters.
module dplca_aging_multi #(
    parameter int NUM_IDS = 256,
    parameter int ID_W    = 8,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dplca_aging_multi_if.slave  bus
);

    localparam logic [2:0] S_DIS  = 3'b000;
    localparam logic [2:0] S_WAIT = 3'b001;
    localparam logic [2:0] S_END  = 3'b010;
    localparam logic [2:0] S_UPD  = 3'b011;
    localparam logic [2:0] S_NTF  = 3'b100;

    localparam logic [1:0] C_HARD = 2'b01;
    localparam logic [1:0] C_NONE = 2'b10;
    localparam logic [1:0] C_SOFT = 2'b11;
    localparam logic [1:0] E_NONE = 2'b00;

    logic [2:0]           r_state;
    logic [2*NUM_IDS-1:0] r_live;
    logic [2*NUM_IDS-1:0] r_new;
    logic [CNT_W-1:0]     r_long;
    logic [CNT_W-1:0]     r_short;
    logic                 r_new_age;
    logic                 r_tbl_upd;

    logic [2:0]           w_state_nxt;
    logic                 w_claim_hs;
    logic                 w_id_zero;
    logic                 w_id_ok;
    logic                 w_enter_end;
    logic                 w_enter_wait;
    logic                 w_enter_ntf;
    logic                 w_hard_due;
    logic                 w_soft_due;
    logic                 w_age_hard;
    logic                 w_age_soft;
    logic                 w_wr_en;
    logic [CNT_W-1:0]     w_long_nxt;
    logic [CNT_W-1:0]     w_short_nxt;
    logic [2*NUM_IDS-1:0] w_live_aged;
    logic [2*NUM_IDS-1:0] w_new_aged;
    logic [2*NUM_IDS-1:0] w_live_wr;
    logic [2*NUM_IDS-1:0] w_new_wr;
    logic [2*NUM_IDS-1:0] w_live_nxt;
    logic [2*NUM_IDS-1:0] w_new_nxt;

    assign w_claim_hs = (bus.dplca_txop_claim == C_HARD)
                     || (bus.dplca_txop_claim == C_SOFT);
    assign w_id_zero  = (bus.dplca_txop_id == '0);
    assign w_id_ok    = (32'(bus.dplca_txop_id) < 32'(NUM_IDS));

    // Aging happens only on the edge that enters TXOP_END for TXOP 0.
    assign w_enter_end = (r_state == S_WAIT) && bus.dplca_txop_end;
    assign w_hard_due  = (r_long  >= bus.hard_aging_cycles);
    assign w_soft_due  = (r_short >= bus.soft_aging_cycles);
    assign w_age_hard  = w_enter_end && w_id_zero && w_hard_due;
    assign w_age_soft  = w_enter_end && w_id_zero && w_soft_due;

    assign w_long_nxt  = w_hard_due ? '0 : r_long  + CNT_W'(1);
    assign w_short_nxt = w_soft_due ? '0 : r_short + CNT_W'(1);

    // Claim write happens on the edge that leaves TXOP_END for UPDATE.
    assign w_wr_en = (r_state == S_END) && w_claim_hs && w_id_ok;

    assign w_enter_wait = (w_state_nxt == S_WAIT) && (r_state != S_WAIT);
    assign w_enter_ntf  = (w_state_nxt == S_NTF)  && (r_state != S_NTF);

    // Next-state decode; an invalid claim keeps the FSM in TXOP_END.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DIS: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dplca_txop_end) w_state_nxt = S_END;
            end
            S_END: begin
                if (w_claim_hs) begin
                    w_state_nxt = S_UPD;
                end else if (bus.dplca_txop_claim == C_NONE) begin
                    w_state_nxt = S_NTF;
                end
            end
            S_UPD: begin
                w_state_nxt = S_NTF;
            end
            S_NTF: begin
                if (!bus.dplca_txop_end) w_state_nxt = S_WAIT;
            end
            default: begin
                w_state_nxt = S_DIS;
            end
        endcase
    end

    // HARD aging first, then SOFT aging on the HARD-aged result.
    always_comb begin
        logic [1:0] w_e_live;
        logic [1:0] w_e_new;
        w_live_aged = r_live;
        w_new_aged  = r_new;
        for (int i = 0; i < NUM_IDS; i++) begin
            w_e_live = r_live[2*i +: 2];
            w_e_new  = r_new[2*i +: 2];
            if (w_age_hard) begin
                if ((w_e_live == C_HARD) || (w_e_new == C_HARD)) begin
                    w_e_live = w_e_new;
                end
                if (w_e_new == C_HARD) w_e_new = E_NONE;
            end
            if (w_age_soft) begin
                if (w_e_live == C_SOFT) begin
                    w_e_live = (w_e_new == C_SOFT) ? C_SOFT : E_NONE;
                end
                if (w_e_new == C_SOFT) w_e_new = E_NONE;
            end
            w_live_aged[2*i +: 2] = w_e_live;
            w_new_aged[2*i +: 2]  = w_e_new;
        end
    end

    // Claim write: HARD overwrites, SOFT never downgrades a HARD entry.
    always_comb begin
        w_live_wr = r_live;
        w_new_wr  = r_new;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (w_wr_en && (bus.dplca_txop_id == ID_W'(i))) begin
                if (bus.dplca_txop_claim == C_HARD) begin
                    w_live_wr[2*i +: 2] = C_HARD;
                    w_new_wr[2*i +: 2]  = C_HARD;
                end else begin
                    if (r_live[2*i +: 2] != C_HARD) begin
                        w_live_wr[2*i +: 2] = C_SOFT;
                    end
                    if (r_new[2*i +: 2] != C_HARD) begin
                        w_new_wr[2*i +: 2] = C_SOFT;
                    end
                end
            end
        end
    end

    assign w_live_nxt = w_enter_end ? w_live_aged
                      : (w_wr_en ? w_live_wr : r_live);
    assign w_new_nxt  = w_enter_end ? w_new_aged
                      : (w_wr_en ? w_new_wr : r_new);

    // FSM state register; aging disable aborts to DISABLED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_DIS;
        end else if (!bus.dplca_aging) begin
            r_state <= S_DIS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Live and shadow claim tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= '0;
            r_new  <= '0;
        end else if (!bus.dplca_aging) begin
            r_live <= '0;
            r_new  <= '0;
        end else begin
            r_live <= w_live_nxt;
            r_new  <= w_new_nxt;
        end
    end

    // HARD and SOFT aging counters advance once per TXOP 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long  <= '0;
            r_short <= '0;
        end else if (!bus.dplca_aging) begin
            r_long  <= '0;
            r_short <= '0;
        end else if (w_enter_end && w_id_zero) begin
            r_long  <= w_long_nxt;
            r_short <= w_short_nxt;
        end
    end

    // Notification flags, cleared each time WAIT is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_age <= 1'b0;
            r_tbl_upd <= 1'b0;
        end else if (!bus.dplca_aging) begin
            r_new_age <= 1'b0;
            r_tbl_upd <= 1'b0;
        end else if (w_enter_wait) begin
            r_new_age <= 1'b0;
            r_tbl_upd <= 1'b0;
        end else begin
            if (w_age_hard || w_age_soft) r_new_age <= 1'b1;
            if (w_enter_ntf)              r_tbl_upd <= 1'b1;
        end
    end

    assign bus.claim_table          = r_live;
    assign bus.state                = r_state;
    assign bus.long_cnt             = r_long;
    assign bus.short_cnt            = r_short;
    assign bus.dplca_new_age        = r_new_age;
    assign bus.dplca_txop_table_upd = r_tbl_upd;

endmodule

// File: tb/tb_dplca_aging_multi.sv
// tb_dplca_aging_multi: directed vector table plus hand-written
// sequences for the aging engine.
module tb_dplca_aging_multi;

    localparam int NUM_IDS = 256;
    localparam int ID_W    = 8;
    localparam int CNT_W   = 16;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;
    localparam logic [1:0] Z = 2'b00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dplca_aging_multi_if #(
        .NUM_IDS(NUM_IDS), .ID_W(ID_W), .CNT_W(CNT_W)
    ) bus ();

    dplca_aging_multi #(
        .NUM_IDS(NUM_IDS), .ID_W(ID_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       ag;
        logic       te;
        logic [1:0] cl;
        logic [7:0] id;
        logic [15:0] hc;
        logic [15:0] sc;
        logic [2:0] st;
        logic [15:0] lc;
        logic [15:0] scn;
        logic       na;
        logic       up;
        int         ix;
        logic [1:0] en;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic ag, input logic te,
                       input logic [1:0] cl, input logic [7:0] id,
                       input logic [15:0] hc, input logic [15:0] sc,
                       input logic [2:0] st, input logic [15:0] lc,
                       input logic [15:0] scn, input logic na,
                       input logic up, input int ix,
                       input logic [1:0] en);
        vec_t v;
        v.ag = ag; v.te = te; v.cl = cl; v.id = id;
        v.hc = hc; v.sc = sc; v.st = st; v.lc = lc;
        v.scn = scn; v.na = na; v.up = up; v.ix = ix; v.en = en;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int n,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h",
                     nm, n, got, exp);
        end
    endtask

    function automatic logic [1:0] ent(input int i);
        return bus.claim_table[2*i +: 2];
    endfunction

    task automatic step(input logic ag, input logic te,
                        input logic [1:0] cl, input logic [7:0] id,
                        input logic [15:0] hc, input logic [15:0] sc);
        bus.dplca_aging       = ag;
        bus.dplca_txop_end    = te;
        bus.dplca_txop_claim  = cl;
        bus.dplca_txop_id     = id;
        bus.hard_aging_cycles = hc;
        bus.soft_aging_cycles = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tg, input int n,
                           input logic [2:0] st, input logic [15:0] lc,
                           input logic [15:0] scn, input logic na,
                           input logic up);
        chk({tg, "_state"}, n, 32'(bus.state), 32'(st));
        chk({tg, "_long"},  n, 32'(bus.long_cnt), 32'(lc));
        chk({tg, "_short"}, n, 32'(bus.short_cnt), 32'(scn));
        chk({tg, "_age"},   n, 32'(bus.dplca_new_age), 32'(na));
        chk({tg, "_upd"},   n, 32'(bus.dplca_txop_table_upd), 32'(up));
    endtask

    initial begin
        // id 5 HARD claim, latency to table_upd
        add(1,0,N,0,2,3, 1,0,0,0,0, 5,Z);
        add(1,1,H,5,2,3, 2,0,0,0,0, 5,Z);
        add(1,1,H,5,2,3, 3,0,0,0,0, 5,H);
        add(1,1,H,5,2,3, 4,0,0,0,1, 5,H);
        add(1,0,H,5,2,3, 1,0,0,0,0, 5,H);
        // HARD counter 1,2, then age; id 5 still in shadow
        add(1,1,N,0,2,3, 2,1,1,0,0, 5,H);
        add(1,1,N,0,2,3, 4,1,1,0,1, 5,H);
        add(1,0,N,0,2,3, 1,1,1,0,0, 5,H);
        add(1,1,N,0,2,3, 2,2,2,0,0, 5,H);
        add(1,1,N,0,2,3, 4,2,2,0,1, 5,H);
        add(1,0,N,0,2,3, 1,2,2,0,0, 5,H);
        add(1,1,N,0,2,3, 2,0,3,1,0, 5,H);
        add(1,1,N,0,2,3, 4,0,3,1,1, 5,H);
        add(1,0,N,0,2,3, 1,0,3,0,0, 5,H);
        // threshold 0: unclaimed id 5 ages out
        add(1,1,N,0,0,9, 2,0,4,1,0, 5,Z);
        add(1,1,N,0,0,9, 4,0,4,1,1, 5,Z);
        add(1,0,N,0,0,9, 1,0,4,0,0, 5,Z);
        add(0,0,N,0,0,9, 0,0,0,0,0, 5,Z);
        // SOFT vs HARD, SOFT aging with threshold 0
        add(1,0,N,0,5,0, 1,0,0,0,0, 7,Z);
        add(1,1,H,7,5,0, 2,0,0,0,0, 7,Z);
        add(1,1,H,7,5,0, 3,0,0,0,0, 7,H);
        add(1,1,H,7,5,0, 4,0,0,0,1, 7,H);
        add(1,0,H,7,5,0, 1,0,0,0,0, 7,H);
        add(1,1,S,7,5,0, 2,0,0,0,0, 7,H);
        add(1,1,S,7,5,0, 3,0,0,0,0, 7,H);
        add(1,1,S,7,5,0, 4,0,0,0,1, 7,H);
        add(1,0,S,7,5,0, 1,0,0,0,0, 7,H);
        add(1,1,S,8,5,0, 2,0,0,0,0, 8,Z);
        add(1,1,S,8,5,0, 3,0,0,0,0, 8,S);
        add(1,1,S,8,5,0, 4,0,0,0,1, 8,S);
        add(1,0,S,8,5,0, 1,0,0,0,0, 8,S);
        add(1,1,N,0,5,0, 2,1,0,1,0, 8,S);
        add(1,1,N,0,5,0, 4,1,0,1,1, 8,S);
        add(1,0,N,0,5,0, 1,1,0,0,0, 8,S);
        add(1,1,N,0,5,0, 2,2,0,1,0, 8,Z);
        add(1,1,N,0,5,0, 4,2,0,1,1, 7,H);
        add(1,0,N,0,5,0, 1,2,0,0,0, 7,H);
        add(0,0,N,0,5,0, 0,0,0,0,0, 7,Z);
        // both classes due on the same TXOP 0
        add(1,0,N,0,1,1, 1,0,0,0,0, 3,Z);
        add(1,1,H,3,1,1, 2,0,0,0,0, 3,Z);
        add(1,1,H,3,1,1, 3,0,0,0,0, 3,H);
        add(1,1,H,3,1,1, 4,0,0,0,1, 3,H);
        add(1,0,H,3,1,1, 1,0,0,0,0, 3,H);
        add(1,1,S,4,1,1, 2,0,0,0,0, 4,Z);
        add(1,1,S,4,1,1, 3,0,0,0,0, 4,S);
        add(1,1,S,4,1,1, 4,0,0,0,1, 4,S);
        add(1,0,S,4,1,1, 1,0,0,0,0, 4,S);
        add(1,1,N,0,1,1, 2,1,1,0,0, 3,H);
        add(1,1,N,0,1,1, 4,1,1,0,1, 4,S);
        add(1,0,N,0,1,1, 1,1,1,0,0, 4,S);
        add(1,1,N,0,1,1, 2,0,0,1,0, 3,H);
        add(1,1,N,0,1,1, 4,0,0,1,1, 4,S);
        add(1,0,N,0,1,1, 1,0,0,0,0, 4,S);
        add(1,1,N,0,1,1, 2,1,1,0,0, 3,H);
        add(1,1,N,0,1,1, 4,1,1,0,1, 3,H);
        add(1,0,N,0,1,1, 1,1,1,0,0, 4,S);
        add(1,1,N,0,1,1, 2,0,0,1,0, 3,Z);
        add(1,1,N,0,1,1, 4,0,0,1,1, 4,Z);
        add(1,0,N,0,1,1, 1,0,0,0,0, 4,Z);

        bus.dplca_aging       = 1'b0;
        bus.dplca_txop_end    = 1'b0;
        bus.dplca_txop_claim  = N;
        bus.dplca_txop_id     = '0;
        bus.hard_aging_cycles = 16'd2;
        bus.soft_aging_cycles = 16'd3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("rst", 0, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("rst_tbl", 0, 32'(bus.claim_table != '0), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            step(vq[k].ag, vq[k].te, vq[k].cl, vq[k].id,
                 vq[k].hc, vq[k].sc);
            chk_out("vec", k, vq[k].st, vq[k].lc, vq[k].scn,
                    vq[k].na, vq[k].up);
            chk("vec_ent", k, 32'(ent(vq[k].ix)), 32'(vq[k].en));
        end

        // invalid claim holds TXOP_END without recounting
        step(1,1,Z,0,1,1);
        chk_out("t5a", 100, 3'd2, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1,1,Z,0,1,1);
        chk_out("t5b", 101, 3'd2, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1,1,Z,0,1,1);
        chk_out("t5c", 102, 3'd2, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1,1,N,0,1,1);
        chk_out("t5d", 103, 3'd4, 16'd1, 16'd1, 1'b0, 1'b1);
        step(1,0,N,0,1,1);
        chk_out("t5e", 104, 3'd1, 16'd1, 16'd1, 1'b0, 1'b0);

        // aging dropped during UPDATE
        step(1,1,H,9,1,1);
        chk_out("t6a", 105, 3'd2, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1,1,H,9,1,1);
        chk_out("t6b", 106, 3'd3, 16'd1, 16'd1, 1'b0, 1'b0);
        chk("t6b_ent", 106, 32'(ent(9)), 32'(H));
        step(0,1,H,9,1,1);
        chk_out("t6c", 107, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("t6c_tbl", 107, 32'(bus.claim_table != '0), 32'd0);

        // claim in TXOP 0 survives its own age, then async reset
        step(1,0,N,0,0,1);
        chk_out("t6d", 108, 3'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        step(1,1,H,0,0,1);
        chk_out("t6e", 109, 3'd2, 16'd0, 16'd1, 1'b1, 1'b0);
        step(1,1,H,0,0,1);
        chk_out("t6f", 110, 3'd3, 16'd0, 16'd1, 1'b1, 1'b0);
        chk("t6f_ent", 110, 32'(ent(0)), 32'(H));
        step(1,1,H,0,0,1);
        chk_out("t6g", 111, 3'd4, 16'd0, 16'd1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("t6h", 112, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("t6h_tbl", 112, 32'(bus.claim_table != '0), 32'd0);
        #5;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
